// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the memory access unit and related memory-side blocks.
//   - maState_t        : access sequencer state encoding
//   - OPC_MSB/OPC_LSB  : opcode field position inside the instruction word
//   - FUNC_MSB         : top bit of the function-code field (field starts at bit 0)
//   - DEFAULT_TIMEOUT  : wait cycles allowed for inputReady before an access aborts
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_RD   = 2'd1,
        MA_WR   = 2'd2,
        MA_DONE = 2'd3
    } maState_t;

    localparam int OPC_MSB         = 15;
    localparam int OPC_LSB         = 12;
    localparam int FUNC_MSB        = 5;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Wait-cycle counter with clear, count enable and an expiry flag. Written to be
// reused by any stage that waits on an external completion strobe.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   clear    in   restart the count at zero (wins over enable)
//   enable   in   count this cycle
//   count    out  current wait count, saturates at LIMIT
//   expired  out  high in the counting cycle whose increment reaches LIMIT
module mem_wait_timer #(
    parameter int CNT_W = 7,
    parameter int LIMIT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] SAT_VALUE  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_VALUE = CNT_W'(LIMIT - 1);

    // The flag is raised one cycle early (on the increment that lands on LIMIT)
    // so the owner can leave its wait state on the same edge the limit is hit.
    assign expired = enable && (count >= LAST_VALUE);

    // Saturating counter: holds at LIMIT rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT_VALUE)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Bridges the multi-cycle control FSM to the external word memory. Converts the
// single-state MemRead/MemWrite requests into a held readM/writeM handshake that
// ends on inputReady, owns the IR and MDR, and stalls control via mem_busy.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   MemRead, MemWrite             level requests from control
//   IorD                          address select (0 = pc, 1 = alu_out)
//   IRWrite                       read destination (1 = IR, 0 = MDR)
//   pc, alu_out, store_data       address sources and write data
//   inputReady, mem_rdata         memory completion strobe and read data
//   readM, writeM                 memory strobes, held for the whole access
//   address, mem_wdata            memory address and write data
//   mem_wdata_oe                  drive enable for an external tristate
//   instruction, opcode, func_code IR contents and decoded fields
//   mdr                           memory data register
//   mem_busy, mem_done, mem_err   stall, completion pulse, sticky error
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [WORD_W-1:0] store_data,
    input  logic              inputReady,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              readM,
    output logic              writeM,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    output logic [WORD_W-1:0] instruction,
    output logic [3:0]        opcode,
    output logic [5:0]        func_code,
    output logic [WORD_W-1:0] mdr,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    maState_t         state;
    logic             destIr;
    logic             waiting;
    logic             accepting;
    logic             timerClear;
    logic             timerEnable;
    logic             timerExpired;
    logic [CNT_W-1:0] waitCount;

    assign opcode    = instruction[OPC_MSB:OPC_LSB];
    assign func_code = instruction[FUNC_MSB:0];

    // The counter restarts whenever a new access is accepted and only runs
    // while a wait state sees no completion strobe.
    assign waiting     = (state == MA_RD) || (state == MA_WR);
    assign accepting   = (state == MA_IDLE) && (MemRead ^ MemWrite);
    assign timerClear  = accepting;
    assign timerEnable = waiting && !inputReady;

    mem_wait_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) waitTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timerClear),
        .enable  (timerEnable),
        .count   (waitCount),
        .expired (timerExpired)
    );

    // Access sequencer. All outputs are registered; mem_done defaults low so it
    // can only ever be a single-cycle pulse on entry to DONE. A simultaneous
    // read and write request is treated as a protocol error and goes straight
    // to DONE without touching the bus.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= MA_IDLE;
            readM        <= 1'b0;
            writeM       <= 1'b0;
            mem_wdata_oe <= 1'b0;
            mem_busy     <= 1'b0;
            mem_done     <= 1'b0;
            mem_err      <= 1'b0;
            address      <= '0;
            mem_wdata    <= '0;
            instruction  <= '0;
            mdr          <= '0;
            destIr       <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                MA_IDLE: begin
                    if (MemRead && MemWrite) begin
                        mem_err  <= 1'b1;
                        mem_done <= 1'b1;
                        state    <= MA_DONE;
                    end else if (MemRead) begin
                        address  <= IorD ? alu_out : pc;
                        destIr   <= IRWrite & ~IorD;
                        readM    <= 1'b1;
                        mem_busy <= 1'b1;
                        state    <= MA_RD;
                    end else if (MemWrite) begin
                        address      <= IorD ? alu_out : pc;
                        mem_wdata    <= store_data;
                        writeM       <= 1'b1;
                        mem_wdata_oe <= 1'b1;
                        mem_busy     <= 1'b1;
                        state        <= MA_WR;
                    end
                end
                MA_RD, MA_WR: begin
                    if (inputReady || timerExpired) begin
                        // Read data is captured on the ready edge itself; a
                        // timeout leaves both IR and MDR untouched.
                        if (inputReady && (state == MA_RD)) begin
                            if (destIr) begin
                                instruction <= mem_rdata;
                            end else begin
                                mdr <= mem_rdata;
                            end
                        end
                        if (!inputReady) begin
                            mem_err <= 1'b1;
                        end
                        readM        <= 1'b0;
                        writeM       <= 1'b0;
                        mem_wdata_oe <= 1'b0;
                        mem_busy     <= 1'b0;
                        mem_done     <= 1'b1;
                        state        <= MA_DONE;
                    end
                end
                MA_DONE: begin
                    state <= MA_IDLE;
                end
                default: begin
                    state <= MA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit: a table of single-cycle-ready reads plus
// hand-written fetch, load, store, timeout, protocol-error and reset sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        IRWrite;
    logic [15:0] pc;
    logic [15:0] alu_out;
    logic [15:0] store_data;
    logic        inputReady;
    logic [15:0] mem_rdata;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    logic [15:0] mem_wdata;
    logic        mem_wdata_oe;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic [5:0]  func_code;
    logic [15:0] mdr;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    int compared;
    int mismatched;

    typedef struct {
        logic        iorD;
        logic        irWrite;
        logic [15:0] pc;
        logic [15:0] aluOut;
        logic [15:0] rdata;
        logic [15:0] expAddr;
        logic [15:0] expInstr;
        logic [15:0] expMdr;
    } vec_t;

    vec_t vecs[5];

    mem_access_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .pc           (pc),
        .alu_out      (alu_out),
        .store_data   (store_data),
        .inputReady   (inputReady),
        .mem_rdata    (mem_rdata),
        .readM        (readM),
        .writeM       (writeM),
        .address      (address),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .instruction  (instruction),
        .opcode       (opcode),
        .func_code    (func_code),
        .mdr          (mdr),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it; inputs are changed and
    // outputs sampled at this point, well away from the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic iorD,
                                 input logic irW, input logic [15:0] pcVal,
                                 input logic [15:0] aluVal, input logic [15:0] sdata,
                                 input logic rdy, input logic [15:0] rdata);
        MemRead    = rd;
        MemWrite   = wr;
        IorD       = iorD;
        IRWrite    = irW;
        pc         = pcVal;
        alu_out    = aluVal;
        store_data = sdata;
        inputReady = rdy;
        mem_rdata  = rdata;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".readM"},    {15'd0, readM},        16'd0);
        checkOutput({tag, ".writeM"},   {15'd0, writeM},       16'd0);
        checkOutput({tag, ".oe"},       {15'd0, mem_wdata_oe}, 16'd0);
        checkOutput({tag, ".busy"},     {15'd0, mem_busy},     16'd0);
        checkOutput({tag, ".done"},     {15'd0, mem_done},     16'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{1'b0, 1'b1, 16'h0100, 16'h0AAA, 16'h1234, 16'h0100, 16'h1234, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 16'h0102, 16'h8000, 16'h5A5A, 16'h8000, 16'h1234, 16'h5A5A};
        vecs[2] = '{1'b1, 1'b1, 16'h0104, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h1234, 16'h0F0F};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h1111, 16'h7777, 16'h0000, 16'h1234, 16'h7777};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFE, 16'h2222, 16'hA5C3, 16'hFFFE, 16'hA5C3, 16'h7777};

        // Reset state
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
        reset_n = 1'b0;
        step();
        step();
        checkIdleOutputs("reset");
        checkOutput("reset.err",   {15'd0, mem_err}, 16'd0);
        checkOutput("reset.addr",  address,          16'h0000);
        checkOutput("reset.wdata", mem_wdata,        16'h0000);
        checkOutput("reset.instr", instruction,      16'h0000);
        checkOutput("reset.mdr",   mdr,              16'h0000);
        reset_n = 1'b1;
        step();

        // Fetch with two not-ready wait cycles
        applyStimulus(1, 0, 0, 1, 16'h0010, 16'h0999, 16'h0, 0, 16'hF01C);
        step();
        checkOutput("fetch.readM1", {15'd0, readM},    16'd1);
        checkOutput("fetch.busy1",  {15'd0, mem_busy}, 16'd1);
        checkOutput("fetch.addr",   address,           16'h0010);
        step();
        checkOutput("fetch.readM2", {15'd0, readM},    16'd1);
        checkOutput("fetch.done2",  {15'd0, mem_done}, 16'd0);
        step();
        checkOutput("fetch.readM3", {15'd0, readM},    16'd1);
        checkOutput("fetch.instr3", instruction,       16'h0000);
        inputReady = 1'b1;
        step();
        checkOutput("fetch.done",   {15'd0, mem_done}, 16'd1);
        checkOutput("fetch.readM4", {15'd0, readM},    16'd0);
        checkOutput("fetch.busy4",  {15'd0, mem_busy}, 16'd0);
        checkOutput("fetch.instr",  instruction,       16'hF01C);
        checkOutput("fetch.mdr",    mdr,               16'h0000);
        MemRead    = 1'b0;
        inputReady = 1'b0;
        step();
        checkOutput("fetch.doneEnd", {15'd0, mem_done},  16'd0);
        checkOutput("fetch.opcode",  {12'd0, opcode},    16'h000F);
        checkOutput("fetch.func",    {10'd0, func_code}, 16'h001C);
        step();
        checkOutput("fetch.noRestart", {15'd0, readM}, 16'd0);

        // Load with immediate ready: done seen after the second edge, sampled
        // by control on the third
        applyStimulus(1, 0, 1, 0, 16'h0020, 16'h0042, 16'h0, 1, 16'hBEEF);
        step();
        checkOutput("load.readM", {15'd0, readM},    16'd1);
        checkOutput("load.addr",  address,           16'h0042);
        checkOutput("load.done1", {15'd0, mem_done}, 16'd0);
        step();
        checkOutput("load.done2", {15'd0, mem_done}, 16'd1);
        checkOutput("load.mdr",   mdr,               16'hBEEF);
        checkOutput("load.instr", instruction,       16'hF01C);
        MemRead    = 1'b0;
        inputReady = 1'b0;
        step();
        checkOutput("load.done3", {15'd0, mem_done}, 16'd0);

        // Store with three not-ready wait cycles
        applyStimulus(0, 1, 1, 0, 16'h0020, 16'h0030, 16'h1234, 0, 16'h0);
        step();
        checkOutput("store.writeM1", {15'd0, writeM},       16'd1);
        checkOutput("store.oe1",     {15'd0, mem_wdata_oe}, 16'd1);
        checkOutput("store.readM",   {15'd0, readM},        16'd0);
        checkOutput("store.addr",    address,               16'h0030);
        checkOutput("store.wdata",   mem_wdata,             16'h1234);
        store_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("store.writeMHeld", {15'd0, writeM}, 16'd1);
            checkOutput("store.wdataHeld",  mem_wdata,       16'h1234);
        end
        inputReady = 1'b1;
        step();
        checkOutput("store.done",    {15'd0, mem_done},     16'd1);
        checkOutput("store.busy",    {15'd0, mem_busy},     16'd0);
        checkOutput("store.writeM",  {15'd0, writeM},       16'd0);
        checkOutput("store.oe",      {15'd0, mem_wdata_oe}, 16'd0);
        checkOutput("store.mdrHeld", mdr,                   16'hBEEF);
        MemWrite   = 1'b0;
        inputReady = 1'b0;
        step();
        checkOutput("store.doneEnd", {15'd0, mem_done}, 16'd0);
        checkOutput("store.err",     {15'd0, mem_err},  16'd0);

        // Table of immediate-ready reads
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1, 0, vecs[v].iorD, vecs[v].irWrite, vecs[v].pc,
                          vecs[v].aluOut, 16'h0, 1, vecs[v].rdata);
            step();
            checkOutput($sformatf("vec%0d.addr", v), address, vecs[v].expAddr);
            step();
            checkOutput($sformatf("vec%0d.done", v),  {15'd0, mem_done}, 16'd1);
            checkOutput($sformatf("vec%0d.instr", v), instruction,       vecs[v].expInstr);
            checkOutput($sformatf("vec%0d.mdr", v),   mdr,               vecs[v].expMdr);
            MemRead    = 1'b0;
            inputReady = 1'b0;
            step();
            checkOutput($sformatf("vec%0d.opcode", v), {12'd0, opcode},
                        {12'd0, vecs[v].expInstr[15:12]});
            checkOutput($sformatf("vec%0d.func", v), {10'd0, func_code},
                        {10'd0, vecs[v].expInstr[5:0]});
        end

        // Reset in RD_WAIT with ready on the same edge
        applyStimulus(1, 0, 0, 1, 16'h0200, 16'h0, 16'h0, 0, 16'hDEAD);
        step();
        checkOutput("rstmid.readM", {15'd0, readM}, 16'd1);
        reset_n    = 1'b0;
        inputReady = 1'b1;
        step();
        checkIdleOutputs("rstmid");
        checkOutput("rstmid.instr", instruction, 16'h0000);
        checkOutput("rstmid.mdr",   mdr,         16'h0000);
        checkOutput("rstmid.addr",  address,     16'h0000);
        reset_n    = 1'b1;
        MemRead    = 1'b0;
        inputReady = 1'b0;
        step();
        checkOutput("rstmid.noDone", {15'd0, mem_done}, 16'd0);

        // Protocol error: both requests high
        applyStimulus(1, 1, 0, 0, 16'h0300, 16'h0, 16'h5555, 0, 16'h0);
        step();
        checkOutput("proto.readM",  {15'd0, readM},    16'd0);
        checkOutput("proto.writeM", {15'd0, writeM},   16'd0);
        checkOutput("proto.busy",   {15'd0, mem_busy}, 16'd0);
        checkOutput("proto.done",   {15'd0, mem_done}, 16'd1);
        checkOutput("proto.err",    {15'd0, mem_err},  16'd1);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        step();
        checkOutput("proto.doneEnd", {15'd0, mem_done}, 16'd0);
        checkOutput("proto.errHeld", {15'd0, mem_err},  16'd1);

        // Timeout: 64 wait cycles with no ready
        reset_n = 1'b0;
        step();
        checkOutput("rst2.err", {15'd0, mem_err}, 16'd0);
        reset_n = 1'b1;
        applyStimulus(1, 0, 0, 1, 16'h0400, 16'h0, 16'h0, 0, 16'hCAFE);
        step();
        checkOutput("tmo.readM", {15'd0, readM}, 16'd1);
        for (int i = 0; i < 63; i++) begin
            step();
        end
        checkOutput("tmo.readMLate", {15'd0, readM},    16'd1);
        checkOutput("tmo.doneLate",  {15'd0, mem_done}, 16'd0);
        checkOutput("tmo.errLate",   {15'd0, mem_err},  16'd0);
        step();
        checkOutput("tmo.done",  {15'd0, mem_done}, 16'd1);
        checkOutput("tmo.err",   {15'd0, mem_err},  16'd1);
        checkOutput("tmo.readM", {15'd0, readM},    16'd0);
        checkOutput("tmo.instr", instruction,       16'h0000);
        checkOutput("tmo.mdr",   mdr,               16'h0000);
        MemRead = 1'b0;
        step();
        step();
        checkOutput("tmo.errSticky", {15'd0, mem_err},  16'd1);
        checkOutput("tmo.doneEnd",   {15'd0, mem_done}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multi-cycle control FSM/datapath and the external 16-bit word memory.
- Turns the control's one-state MemRead/MemWrite/IorD/IRWrite requests into a held readM/writeM bus handshake terminated by inputReady.
- Owns the instruction register (IR) and memory data register (MDR). Decodes opcode/func_code from IR for the control block.
- Raises mem_busy so the control FSM stalls its state advance until the access completes.

Parameters:
- WORD_W, 16, data and address width.
- TIMEOUT, 64, maximum wait cycles for inputReady before the access aborts.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- MemRead  in  1  read request from control, level.
- MemWrite  in  1  write request from control, level.
- IorD  in  1  address select: 0 = pc, 1 = alu_out.
- IRWrite  in  1  read result goes to IR (1) or MDR (0).
- pc  in  WORD_W  current PC.
- alu_out  in  WORD_W  ALUOut register (data address).
- store_data  in  WORD_W  register B value for SWD.
- inputReady  in  1  memory completion strobe.
- mem_rdata  in  WORD_W  memory read data, valid when inputReady=1.
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  WORD_W  memory address.
- mem_wdata  out  WORD_W  write data.
- mem_wdata_oe  out  1  write data drive enable, for an external tristate.
- instruction  out  WORD_W  IR contents.
- opcode  out  4  IR[15:12], combinational from IR.
- func_code  out  6  IR[5:0], combinational from IR.
- mdr  out  WORD_W  MDR contents.
- mem_busy  out  1  access in flight; control must not advance state.
- mem_done  out  1  one-cycle pulse on access completion or abort.
- mem_err  out  1  sticky; set on timeout or protocol error.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - readM, writeM, mem_wdata_oe, mem_busy, mem_done and mem_err all go to 0.
  - address, mem_wdata, instruction, mdr and the wait counter all go to 0.
  - Reset mid-access aborts the access immediately, with no IR/MDR update and no mem_done.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, request handling:
  - MemRead=1 and MemWrite=0: on the next edge, latch address = IorD ? alu_out : pc, latch dest = IRWrite & ~IorD, clear the counter, assert readM and mem_busy, go to RD_WAIT.
  - MemWrite=1 and MemRead=0: latch address, set mem_wdata = store_data, assert writeM, mem_wdata_oe and mem_busy, go to WR_WAIT.
  - Both high: no access starts; mem_err is set and mem_done pulses for one cycle. Outputs then behave as DONE, and the block returns to IDLE.
- RD_WAIT and WR_WAIT:
  - address, mem_wdata and the strobes are held stable.
  - The counter increments every cycle that inputReady=0.
  - inputReady=1 in RD_WAIT: mem_rdata is captured on that same edge, into instruction if dest=1, else into mdr. Go to DONE.
  - inputReady=1 in WR_WAIT: go to DONE.
  - Counter reaches TIMEOUT with no inputReady: go to DONE with mem_err set and no IR/MDR update.
- DONE:
  - Lasts exactly 1 cycle, with mem_done=1 and mem_busy=0.
  - readM, writeM and mem_wdata_oe are 0.
  - Then go to IDLE.
- Latency: minimum 3 edges from the request being sampled to mem_done (accept, ready, done) when inputReady is already high in the first wait cycle.
- Requester rule: the requester deasserts MemRead/MemWrite in the cycle it sees mem_done. A request still high in IDLE after DONE starts a new access.
- inputReady outside a wait state is ignored.
- IR/MDR hold their value between accesses. opcode and func_code update the cycle after the IR loads.
- Counter saturates and does not wrap.

Decomposition:
- Shared package/include (alongside opcodes.v):
  - State encodings MA_IDLE=2'd0, MA_RD=2'd1, MA_WR=2'd2, MA_DONE=2'd3.
  - Field positions OPC_MSB=15, OPC_LSB=12, FUNC_MSB=5.
  - Default TIMEOUT.
- Sub-module: mem_wait_timer (counter with clear, enable and expired flag), reusable by the future cache/IO stage. Everything else stays in one module.

Test Plan:
- Fetch: IorD=0, IRWrite=1, pc=16'h0010, MemRead pulse, memory returns 16'hF01C after 2-cycle delay → readM held 3 cycles, address=16'h0010, instruction=16'hF01C, opcode=4'hF, func_code=6'h1C, mdr unchanged, one mem_done pulse.
- Load: IorD=1, alu_out=16'h0042, IRWrite=0, mem_rdata=16'hBEEF with immediate ready → mdr=16'hBEEF, instruction unchanged, mem_done on the 3rd edge after the request.
- Store: MemWrite, alu_out=16'h0030, store_data=16'h1234, ready after 4 cycles → writeM and mem_wdata_oe high until the ready edge, mem_wdata=16'h1234, mem_busy low in DONE.
- Timeout: MemRead with inputReady tied 0 → after TIMEOUT=64 wait cycles, mem_done pulses, mem_err=1 and stays 1, IR/MDR unchanged, readM drops.
- Protocol error: MemRead=MemWrite=1 in IDLE → no strobe asserted, mem_err=1, mem_done pulse.
- Reset mid-read: reset_n low in RD_WAIT with inputReady=1 on the same edge → IR unchanged (0), all outputs at reset values, no mem_done.
